// File: rtl/rotate_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rotate_frame_ctrl: loads one raster frame into a single-port SRAM, then
// streams it back rotated (0/90CW/180/90CCW) with line and frame markers.
// Revision: 1.0
// ============================================================================
module rotate_frame_ctrl #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        rot_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              sram_we,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata
);

  localparam int MAXD  = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CNT_W = $clog2(MAXD) + 1;

  localparam logic [ADDR_W-1:0] C_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_W        = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] C_LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] C_BOTTOM   = ADDR_W'((IMG_H - 1) * IMG_W);
  localparam logic [ADDR_W-1:0] C_RIGHT    = ADDR_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TURN  = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rot_q, rot_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d;
  logic                pend_q, pend_eol_q, pend_eof_q;
  logic [1:0][7:0]     fifo_data_q;
  logic [1:0]          fifo_eol_q, fifo_eof_q;
  logic                wptr_q, rptr_q;
  logic [1:0]          fcnt_q;

  logic                w_write, w_issue, w_push, w_pop, w_valid;
  logic                w_col_last, w_last;
  logic [1:0]          w_fcnt_d;
  logic [CNT_W-1:0]    w_ow_last, w_oh_last;
  logic [ADDR_W-1:0]   w_col_step, w_row_step, w_start_addr;

  // Rotation geometry: per-pixel and per-row address deltas replace multipliers.
  always_comb begin
    w_ow_last    = rot_q[0] ? CNT_W'(IMG_H - 1) : CNT_W'(IMG_W - 1);
    w_oh_last    = rot_q[0] ? CNT_W'(IMG_W - 1) : CNT_W'(IMG_H - 1);
    w_col_step   = C_ONE;
    w_row_step   = C_W;
    w_start_addr = '0;
    case (rot_q)
      2'd1: begin
        w_col_step   = '0 - C_W;
        w_row_step   = C_ONE;
        w_start_addr = C_BOTTOM;
      end
      2'd2: begin
        w_col_step   = '0 - C_ONE;
        w_row_step   = '0 - C_W;
        w_start_addr = C_LAST_PIX;
      end
      2'd3: begin
        w_col_step   = C_W;
        w_row_step   = '0 - C_ONE;
        w_start_addr = C_RIGHT;
      end
      default: ;
    endcase
  end

  assign w_write    = (state_q == S_LOAD) && in_valid;
  assign w_issue    = (state_q == S_READ) && ((fcnt_q + {1'b0, pend_q}) < 2'd2);
  assign w_col_last = (col_q == w_ow_last);
  assign w_last     = w_col_last && (row_q == w_oh_last);
  assign w_valid    = (fcnt_q != 2'd0);
  assign w_push     = pend_q;
  assign w_pop      = w_valid && out_ready;
  assign w_fcnt_d   = fcnt_q + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    sram_we    = w_write;
    sram_re    = w_issue;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_write) begin
          sram_addr  = wr_cnt_q;
          sram_wdata = in_data;
          if (wr_cnt_q == C_LAST_PIX) state_d = S_TURN;
        end
      end
      S_TURN: state_d = S_READ;
      S_READ: begin
        if (w_issue) begin
          sram_addr = addr_q;
          if (w_last) state_d = S_DRAIN;
        end
      end
      // The eof pop empties the FIFO, so DONE lands the cycle after that handshake.
      S_DRAIN: if (w_fcnt_d == 2'd0) state_d = S_DONE;
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rot_d    = rot_q;
    wr_cnt_d = wr_cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    base_d   = base_q;
    case (state_q)
      S_IDLE: if (start) begin
        rot_d    = rot_sel;
        wr_cnt_d = '0;
      end
      S_LOAD: if (w_write) wr_cnt_d = wr_cnt_q + C_ONE;
      S_TURN: begin
        row_d  = '0;
        col_d  = '0;
        addr_d = w_start_addr;
        base_d = w_start_addr;
      end
      S_READ: if (w_issue) begin
        if (w_col_last) begin
          col_d  = '0;
          row_d  = row_q + C_CNT_ONE;
          base_d = base_q + w_row_step;
          addr_d = base_q + w_row_step;
        end else begin
          col_d  = col_q + C_CNT_ONE;
          addr_d = addr_q + w_col_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_q       <= '0;
      wr_cnt_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      pend_q      <= 1'b0;
      pend_eol_q  <= 1'b0;
      pend_eof_q  <= 1'b0;
      fifo_data_q <= '0;
      fifo_eol_q  <= '0;
      fifo_eof_q  <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      rot_q      <= rot_d;
      wr_cnt_q   <= wr_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      pend_q     <= w_issue;
      pend_eol_q <= w_col_last;
      pend_eof_q <= w_last;
      fcnt_q     <= w_fcnt_d;
      if (w_push) begin
        fifo_data_q[wptr_q] <= sram_rdata;
        fifo_eol_q[wptr_q]  <= pend_eol_q;
        fifo_eof_q[wptr_q]  <= pend_eof_q;
        wptr_q              <= ~wptr_q;
      end
      if (w_pop) rptr_q <= ~rptr_q;
    end
  end

  assign out_valid = w_valid;
  assign out_data  = fifo_data_q[rptr_q];
  assign out_eol   = w_valid && fifo_eol_q[rptr_q];
  assign out_eof   = w_valid && fifo_eof_q[rptr_q];

endmodule
`default_nettype wire

// File: doc/rotate_frame_ctrl.md
Name: rotate_frame_ctrl

Overview:
- Sequencer for the single-port frame SRAM inside the image rotation path.
- Phase 1 (LOAD) writes one raster frame into the SRAM from a valid/ready stream.
- Phase 2 (READ) reads the frame back in rotated order (0/90CW/180/90CCW) into a valid/ready output stream, with line and frame markers.
- Replaces the free-running mode-pin sequencing: one start pulse runs a full frame, with backpressure on both sides.

Parameters:
IMG_W, 512, input frame width in pixels
IMG_H, 512, input frame height in pixels
ADDR_W, 18, SRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run one frame; honoured only in IDLE
rot_sel  in  2  0=0deg, 1=90CW, 2=180, 3=90CCW; sampled on accepted start
in_valid  in  1  input pixel valid
in_ready  out  1  high only in LOAD
in_data  in  8  input pixel, raster order
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts
out_data  out  8  rotated pixel
out_eol  out  1  qualifies out_valid: last pixel of an output row
out_eof  out  1  qualifies out_valid: last pixel of the frame
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at the end of a frame
sram_we  out  1  write strobe
sram_re  out  1  read strobe
sram_addr  out  ADDR_W  address
sram_wdata  out  8  write data
sram_rdata  in  8  read data, valid exactly 1 cycle after sram_re

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. Counters and 2-entry output FIFO cleared. Applies mid-frame; the partial frame is abandoned and no frame_done is issued.
- States and transitions:
  - IDLE -> LOAD on start=1. rot_sel is latched here; later changes are ignored until the next start.
  - LOAD -> TURN after IMG_W*IMG_H accepted writes.
  - TURN -> READ after 1 cycle.
  - READ -> DRAIN in the cycle after the last sram_re.
  - DRAIN -> DONE when the FIFO is empty and no read is outstanding.
  - DONE -> IDLE after 1 cycle.
- start outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, in the same cycle (combinational): sram_we=1, sram_addr=wr_cnt, sram_wdata=in_data. wr_cnt then increments from 0.
  - in_valid gaps stall the counter; no write occurs in a gap cycle.
- READ:
  - Output geometry: for rot 0/2, OW=IMG_W and OH=IMG_H; for rot 1/3, OW=IMG_H and OH=IMG_W.
  - Output counters: row r in 0..OH-1, column c in 0..OW-1, raster order.
  - Read address by rot_sel:
    - 0: r*IMG_W+c
    - 1: (IMG_H-1-c)*IMG_W+r
    - 2: (IMG_H-1-r)*IMG_W+(IMG_W-1-c)
    - 3: c*IMG_W+(IMG_W-1-r)
  - No multipliers: use incremental add/subtract address stepping.
  - sram_re=1 with the computed address whenever (FIFO occupancy + outstanding reads) < 2. Each read carries eol=(c==OW-1) and eof=(last pixel) tags into the FIFO.
  - First sram_re occurs in the first READ cycle; first out_valid occurs 2 cycles after READ entry.
- Output: out_valid = FIFO not empty; out_data, out_eol and out_eof come from the FIFO head.
- Backpressure: while out_valid=1 and out_ready=0, out_data and tags hold stable; no pixel is dropped or duplicated.
- FIFO full with a read in flight is impossible by the credit rule; simultaneous push and pop are allowed.
- frame_done=1 in the DONE cycle, i.e. the cycle after the handshake of the eof pixel (via DRAIN). busy=0 from the next cycle.
- sram_we and sram_re are never high together. Both are 0 in IDLE, TURN, DRAIN and DONE.

Test Plan:
- IMG_W=IMG_H=4, input pixels 0..15, rot 0, out_ready=1 -> output 0..15; eol on 3,7,11,15; eof on 15; frame_done one cycle after the 15 handshake; first out_valid 2 cycles after READ entry.
- Same input, rot 1 -> output 12,8,4,0,13,9,5,1,14,10,6,2,15,11,7,3. Rot 2 -> 15..0. Rot 3 -> 3,7,11,15,2,6,10,14,...,0,4,8,12.
- IMG_W=4, IMG_H=2, input 0..7, rot 1 -> output 4,0,5,1,6,2,7,3; eol every 2nd pixel; eof on 3.
- Rot 1, out_ready low for 10 cycles mid-row, then random toggling -> output sequence identical to the free-running case; out_data stable while stalled; never more than 2 reads in flight. LOAD with random in_valid gaps -> correct write addresses; sram_we only on handshakes.
- start pulsed during LOAD and READ -> ignored. rot_sel changed mid-frame -> no effect on the current frame.
- rst=0 asserted mid-READ -> all outputs 0 immediately (async), no frame_done. After release, start with rot 0 -> a full correct frame from the reloaded input.
